// File: rtl/lfsr_seq_ctrl.sv
// Command sequencer around a 4-bit feedback shift counter: LOAD / STEP / SEEK / RESEED.
// Optional all-zero abort when LFSR_LOCKUP_DET_EN is defined.
module lfsr_seq_ctrl #(
  parameter int               WIDTH = 4,
  parameter logic [WIDTH-1:0] TAPS  = 4'b0011,
  parameter logic [WIDTH-1:0] SEED  = 4'b1001,
  parameter int               CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [1:0]       cmd_op,
  input  logic [WIDTH-1:0] cmd_arg,
  input  logic [CNT_W-1:0] cmd_cnt,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] q_n,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] cycles,
  output logic             timeout,
  output logic             lockup
);

  typedef enum logic [2:0] {IDLE, LOAD, STEP, SEEK, DONE} state_t;

  state_t           state;
  logic [WIDTH-1:0] arg;
  logic [CNT_W-1:0] cnt;
  logic             reseed;
  logic             lock_hit;
  logic [WIDTH-1:0] q_adv;

  assign q_adv = {^(q & TAPS), q[WIDTH-1:1]};

`ifdef LFSR_LOCKUP_DET_EN
  assign lock_hit = (q == '0);
`else
  // Without detection all-zero is simply a fixed point of the step rule.
  assign lock_hit = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      q         <= SEED;
      q_n       <= ~SEED;
      arg       <= '0;
      cnt       <= '0;
      reseed    <= 1'b0;
      cmd_ready <= 1'b1;
      busy      <= 1'b0;
      done      <= 1'b0;
      cycles    <= '0;
      timeout   <= 1'b0;
      lockup    <= 1'b0;
    end else begin
      case (state)
        IDLE: if (cmd_valid) begin
          arg       <= cmd_arg;
          cnt       <= cmd_cnt;
          cycles    <= '0;
          timeout   <= 1'b0;
          lockup    <= 1'b0;
          cmd_ready <= 1'b0;
          busy      <= 1'b1;
          case (cmd_op)
            2'b00: begin state <= LOAD; reseed <= 1'b0; end
            2'b11: begin state <= LOAD; reseed <= 1'b1; end
            2'b01: begin
              if (cmd_cnt == '0) begin
                state <= DONE;
                done  <= 1'b1;
              end else begin
                state <= STEP;
              end
            end
            default: state <= SEEK;
          endcase
        end
        LOAD: begin
          q     <= reseed ? SEED : arg;
          q_n   <= reseed ? ~SEED : ~arg;
          state <= DONE;
          done  <= 1'b1;
        end
        STEP: begin
          if (lock_hit) begin
            q      <= SEED;
            q_n    <= ~SEED;
            lockup <= 1'b1;
            state  <= DONE;
            done   <= 1'b1;
          end else begin
            q      <= q_adv;
            q_n    <= ~q_adv;
            cycles <= cycles + 1'b1;
            if (cycles + 1'b1 == cnt) begin
              state <= DONE;
              done  <= 1'b1;
            end
          end
        end
        SEEK: begin
          // Compare before advancing so a match at accept costs zero steps.
          if (lock_hit) begin
            q      <= SEED;
            q_n    <= ~SEED;
            lockup <= 1'b1;
            state  <= DONE;
            done   <= 1'b1;
          end else if (q == arg) begin
            state <= DONE;
            done  <= 1'b1;
          end else if (cycles == cnt) begin
            timeout <= 1'b1;
            state   <= DONE;
            done    <= 1'b1;
          end else begin
            q      <= q_adv;
            q_n    <= ~q_adv;
            cycles <= cycles + 1'b1;
          end
        end
        DONE: begin
          state     <= IDLE;
          done      <= 1'b0;
          busy      <= 1'b0;
          cmd_ready <= 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_lfsr_seq_ctrl.sv
// Directed bench for lfsr_seq_ctrl; expected values hand-derived from the 1001 / Q0^Q1 sequence.
module tb_lfsr_seq_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [1:0] cmd_op;
  logic [3:0] cmd_arg;
  logic [7:0] cmd_cnt;
  logic [3:0] q, q_n;
  logic       busy, done, timeout, lockup;
  logic [7:0] cycles;

  int nvec = 0;
  int nerr = 0;
  int lat;
  logic got;

  lfsr_seq_ctrl dut (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_arg(cmd_arg), .cmd_cnt(cmd_cnt),
    .q(q), .q_n(q_n), .busy(busy), .done(done), .cycles(cycles),
    .timeout(timeout), .lockup(lockup)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got_v, input logic [31:0] exp_v);
    nvec++;
    if (got_v !== exp_v) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h", tag, got_v, exp_v);
    end
  endtask

  // Issue one command at a negedge, then wait (bounded) for the done pulse.
  task automatic run_cmd(input logic [1:0] op, input logic [3:0] a, input logic [7:0] c);
    @(negedge clk);
    chk("ready_idle", cmd_ready, 1);
    cmd_op = op; cmd_arg = a; cmd_cnt = c; cmd_valid = 1'b1;
    got = 1'b0; lat = 0;
    for (int i = 1; i <= 400 && !got; i++) begin
      @(negedge clk);
      cmd_valid = 1'b0;
      if (done) begin got = 1'b1; lat = i; end
      else if (i == 1) chk("busy", busy, 1);
    end
    if (!got) chk("done_seen", 0, 1);
  endtask

  task automatic after_done;
    @(negedge clk);
    chk("done_pulse", done, 0);
    chk("ready_after", cmd_ready, 1);
  endtask

  initial begin
    rst = 1'b1; cmd_valid = 1'b0; cmd_op = '0; cmd_arg = '0; cmd_cnt = '0;
    repeat (2) @(negedge clk);
    chk("rst_q", q, 4'b1001);
    chk("rst_qn", q_n, 4'b0110);
    chk("rst_ready", cmd_ready, 1);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_cycles", cycles, 0);
    rst = 1'b0;

    run_cmd(2'b01, 4'h0, 8'd1);
    chk("step1_q", q, 4'b1100);
    chk("step1_qn", q_n, 4'b0011);
    chk("step1_cyc", cycles, 1);
    chk("step1_lat", lat, 2);
    after_done();

    run_cmd(2'b11, 4'h0, 8'd0);
    chk("reseed_q", q, 4'b1001);
    chk("reseed_cyc", cycles, 0);
    chk("reseed_lat", lat, 2);
    after_done();

    run_cmd(2'b01, 4'h0, 8'd15);
    chk("step15_q", q, 4'b1001);
    chk("step15_cyc", cycles, 15);
    chk("step15_lat", lat, 16);
    after_done();

    run_cmd(2'b10, 4'b0001, 8'd20);
    chk("seek1_q", q, 4'b0001);
    chk("seek1_cyc", cycles, 11);
    chk("seek1_to", timeout, 0);
    after_done();

    run_cmd(2'b11, 4'h0, 8'd0);
    after_done();
    run_cmd(2'b10, 4'b0000, 8'd20);
    chk("seek0_to", timeout, 1);
    chk("seek0_cyc", cycles, 20);
    chk("seek0_q", q, 4'b1010);
    after_done();
    chk("seek0_hold", timeout, 1);

    run_cmd(2'b10, 4'b1010, 8'd5);
    chk("seekhit_cyc", cycles, 0);
    chk("seekhit_to", timeout, 0);
    chk("seekhit_q", q, 4'b1010);
    after_done();

    run_cmd(2'b00, 4'b0110, 8'd0);
    chk("load_q", q, 4'b0110);
    chk("load_qn", q_n, 4'b1001);
    chk("load_lat", lat, 2);
    after_done();

    run_cmd(2'b01, 4'h0, 8'd0);
    chk("step0_q", q, 4'b0110);
    chk("step0_cyc", cycles, 0);
    after_done();

    run_cmd(2'b00, 4'b0000, 8'd0);
    after_done();
    run_cmd(2'b01, 4'h0, 8'd3);
`ifdef LFSR_LOCKUP_DET_EN
    chk("lock_flag", lockup, 1);
    chk("lock_q", q, 4'b1001);
    chk("lock_cyc", cycles, 0);
`else
    chk("lock_flag", lockup, 0);
    chk("lock_q", q, 4'b0000);
    chk("lock_cyc", cycles, 3);
`endif
    chk("lock_to", timeout, 0);
    after_done();

    // Reset in the middle of a long STEP: aborted, never signals done.
    run_cmd(2'b11, 4'h0, 8'd0);
    after_done();
    @(negedge clk);
    cmd_op = 2'b01; cmd_cnt = 8'd10; cmd_valid = 1'b1;
    @(negedge clk);
    cmd_valid = 1'b0;
    got = 1'b0;
    repeat (3) begin
      @(negedge clk);
      if (done) got = 1'b1;
    end
    chk("mid_busy", busy, 1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    if (done) got = 1'b1;
    chk("mid_nodone", got, 0);
    chk("mid_q", q, 4'b1001);
    chk("mid_busy0", busy, 0);
    chk("mid_ready", cmd_ready, 1);
    chk("mid_cyc", cycles, 0);
    repeat (3) begin
      @(negedge clk);
      chk("mid_quiet", done, 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
